// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central sequencer for the pipeline registers of a 5-stage RISC-V core.
// Each pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) takes its load
// enable from this block. IF/ID and ID/EX also take a flush (clear-to-bubble)
// control from here.
//
// Hazards resolved, highest priority first:
//   1. halt         : ecall/ebreak reached WB. The core freezes until reset.
//   2. memory wait  : the MEM-stage data access has not been acknowledged.
//                     The whole pipe freezes. If the wait runs too long,
//                     mem_err is raised and the core halts.
//   3. branch flush : a taken branch/jump in EX squashes IF/ID and ID/EX.
//   4. load-use     : the instruction in ID needs the result of a load in EX.
//                     PC and IF/ID hold, and a bubble is inserted into ID/EX.
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous, active-low reset
//   id_rs1, id_rs2   source registers of the instruction in ID
//   ex_rd            destination register of the instruction in EX
//   ex_mem_read      instruction in EX is a load
//   ex_branch_taken  branch/jump in EX resolved taken
//   mem_req          MEM-stage data access pending
//   mem_ack          data memory completes the access this cycle
//   wb_halt          ecall/ebreak in WB
//   *_load           pipeline register load enables (combinational)
//   ifid_flush,
//   idex_flush       clear-to-bubble controls (combinational)
//   mem_err          sticky data-memory timeout flag (registered)
//   ctrl_state       0 RUN, 1 MEM_WAIT, 2 HALT (registered)
//   stall_count      saturating count of non-HALT cycles with pc_load = 0
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  input  logic                  wb_halt,
  output logic                  pc_load,
  output logic                  ifid_load,
  output logic                  idex_load,
  output logic                  exmem_load,
  output logic                  memwb_load,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  mem_err,
  output logic [1:0]            ctrl_state,
  output logic [CNT_W-1:0]      stall_count
);

  // The wait counter has to be able to hold MEM_TIMEOUT itself.
  localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  // All pipeline controls as one bundle. The field order runs from MSB to LSB.
  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_FREEZE  = ctrl_t'(7'b00000_00);
  localparam ctrl_t CTRL_ADVANCE = ctrl_t'(7'b11111_00);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q,   state_d;
  logic [WAIT_W-1:0] wait_q,    wait_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_q,   stall_d;

  // ---------------------------------------------------------------------------
  // Hazard decode
  // ---------------------------------------------------------------------------
  logic load_use;
  logic mem_wait;

  // x0 is hard-wired to zero. A load targeting it can never cause a hazard.
  assign load_use = ex_mem_read & (ex_rd != '0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign mem_wait = mem_req & ~mem_ack;

  // Controls for a cycle in which the pipe is free to move. Used from RUN,
  // and from MEM_WAIT on the cycle the acknowledge arrives. A taken branch
  // wins over load-use because the dependent instruction in ID is squashed
  // anyway. Stalling for it would only waste a cycle.
  function automatic ctrl_t issue_ctrl(input logic branch, input logic lu);
    ctrl_t c;
    c = CTRL_ADVANCE;
    if (branch) begin
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (lu) begin
      // Hold PC and IF/ID so the dependent instruction is re-decoded.
      // Let ID/EX load a bubble so the load moves ahead on its own.
      c.pc         = 1'b0;
      c.ifid       = 1'b0;
      c.idex_flush = 1'b1;
    end
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  ctrl_t ctrl_raw;

  always_comb begin
    // NOTE: every signal written here gets a value before any branch.
    // Any path that skipped one would make synthesis infer a latch.
    ctrl_raw  = CTRL_FREEZE;
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;

    unique case (state_q)
      ST_RUN: begin
        if (wb_halt) begin
          state_d = ST_HALT;
        end else if (mem_wait) begin
          // The first stalled cycle happens here, so counting starts at 1.
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_ONE;
        end else begin
          ctrl_raw = issue_ctrl(ex_branch_taken, load_use);
        end
      end

      ST_MEM_WAIT: begin
        if (wb_halt) begin
          state_d = ST_HALT;
        end else if (mem_ack) begin
          ctrl_raw = issue_ctrl(ex_branch_taken, load_use);
          state_d  = ST_RUN;
          wait_d   = '0;
        end else if (wait_q == WAIT_LIMIT) begin
          state_d   = ST_HALT;
          mem_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end

      ST_HALT: begin
        // Only reset leaves HALT. All controls stay frozen.
      end

      default: begin
        // Unreachable encoding. Recover to RUN with the pipe frozen.
        state_d = ST_RUN;
      end
    endcase
  end

  // Count every non-HALT cycle in which the front end does not advance.
  // The count saturates instead of wrapping.
  always_comb begin
    stall_d = stall_q;
    if (!ctrl_raw.pc && (state_q != ST_HALT) && (stall_q != '1)) begin
      stall_d = stall_q + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      // NOTE: use non-blocking assignments for state. All registers then
      // update together at the edge, whatever order the statements are in.
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Reset also gates the combinational controls. While reset is held, no
  // pipeline register can load, whatever the hazard inputs are.
  ctrl_t ctrl_out;
  assign ctrl_out = rst ? ctrl_raw : CTRL_FREEZE;

  assign pc_load     = ctrl_out.pc;
  assign ifid_load   = ctrl_out.ifid;
  assign idex_load   = ctrl_out.idex;
  assign exmem_load  = ctrl_out.exmem;
  assign memwb_load  = ctrl_out.memwb;
  assign ifid_flush  = ctrl_out.ifid_flush;
  assign idex_flush  = ctrl_out.idex_flush;

  assign mem_err     = mem_err_q;
  assign ctrl_state  = state_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Drives pipe_hazard_ctrl with directed hazard sequences and then random
// traffic. A behavioural model predicts the expected controls and registered
// status for every cycle and pushes them into a queue. A separate monitor pops
// each expectation in mid-cycle and compares it with the DUT.
// The stall counter is built narrow here so its saturation can be reached.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int RA_W     = 5;
  localparam int TIMEOUT  = 15;
  localparam int CNT_W    = 6;
  localparam int CNT_SAT  = (1 << CNT_W) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [RA_W-1:0] id_rs1, id_rs2, ex_rd;
  logic            ex_mem_read, ex_branch_taken, mem_req, mem_ack, wb_halt;
  logic            pc_load, ifid_load, idex_load, exmem_load, memwb_load;
  logic            ifid_flush, idex_flush, mem_err;
  logic [1:0]      ctrl_state;
  logic [CNT_W-1:0] stall_count;

  pipe_hazard_ctrl #(
    .REG_ADDR_W (RA_W),
    .MEM_TIMEOUT(TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .wb_halt        (wb_halt),
    .pc_load        (pc_load),
    .ifid_load      (ifid_load),
    .idex_load      (idex_load),
    .exmem_load     (exmem_load),
    .memwb_load     (memwb_load),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .mem_err        (mem_err),
    .ctrl_state     (ctrl_state),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            rst;
    logic [RA_W-1:0] rs1, rs2, rd;
    logic            memrd, br, req, ack, halt;
  } stim_t;

  // ctrl bits, MSB first: pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush
  typedef struct packed {
    logic [6:0]       ctrl;
    logic [1:0]       st;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state. mode: 0 running, 1 waiting on memory, 2 halted.
  int   m_mode   = 0;
  int   m_waited = 0;
  logic m_err    = 1'b0;
  int   m_stalls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Predicts this cycle's outputs, then advances the model across the edge.
  task automatic model(input stim_t s, output exp_t e);
    logic       lu;
    logic       moves;
    int         next_mode;
    logic [6:0] c;
    e = '0;
    if (!s.rst) begin
      m_mode = 0; m_waited = 0; m_err = 1'b0; m_stalls = 0;
      return;
    end
    e.st  = 2'(m_mode);
    e.err = m_err;
    e.cnt = CNT_W'(m_stalls);
    lu = s.memrd && (s.rd != 0) && ((s.rd == s.rs1) || (s.rd == s.rs2));
    moves = 1'b0;
    next_mode = m_mode;
    c = 7'b0000000;
    if (m_mode == 0) begin
      if (s.halt) next_mode = 2;
      else if (s.req && !s.ack) begin next_mode = 1; m_waited = 1; end
      else moves = 1'b1;
    end else if (m_mode == 1) begin
      if (s.halt) next_mode = 2;
      else if (s.ack) begin moves = 1'b1; next_mode = 0; m_waited = 0; end
      else if (m_waited == TIMEOUT) begin next_mode = 2; m_err = 1'b1; end
      else m_waited++;
    end
    if (moves) c = s.br ? 7'b1111111 : (lu ? 7'b0011101 : 7'b1111100);
    if (!c[6] && (m_mode != 2) && (m_stalls < CNT_SAT)) m_stalls++;
    e.ctrl = c;
    m_mode = next_mode;
  endtask

  // One cycle of stimulus. Inputs change just after the rising edge.
  task automatic step(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; ex_rd = s.rd;
    ex_mem_read = s.memrd; ex_branch_taken = s.br;
    mem_req = s.req; mem_ack = s.ack; wb_halt = s.halt;
    model(s, e);
    exp_q.push_back(e);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1; s.rs1 = 5'd1; s.rs2 = 5'd2; s.rd = 5'd0;
    s.memrd = 1'b0; s.br = 1'b0; s.req = 1'b0; s.ack = 1'b0; s.halt = 1'b0;
    return s;
  endfunction

  // Monitor: compares the DUT against the oldest expectation, in mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("controls", 32'({pc_load, ifid_load, idex_load, exmem_load, memwb_load,
                               ifid_flush, idex_flush}), 32'(e.ctrl));
        check("ctrl_state",  32'(ctrl_state),  32'(e.st));
        check("mem_err",     32'(mem_err),     32'(e.err));
        check("stall_count", 32'(stall_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0; wb_halt = 1'b0;

    // Reset is held with hazard inputs active. The outputs must stay frozen.
    s = idle(); s.rst = 1'b0; s.memrd = 1'b1; s.rd = 5'd1; s.br = 1'b1;
    repeat (3) step(s);
    s = idle();
    repeat (5) step(s);

    // Load-use hazard on rs2, then the same pattern with ex_rd = x0.
    s = idle(); s.memrd = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5;
    step(s);
    step(idle());
    s.rd = 5'd0; s.rs2 = 5'd0;
    step(s);
    // A taken branch together with a load-use condition.
    s = idle(); s.memrd = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.br = 1'b1;
    step(s);
    step(idle());

    // Memory wait: ack stays low for 3 cycles, then arrives with a branch.
    s = idle(); s.req = 1'b1;
    repeat (3) step(s);
    s.ack = 1'b1; s.br = 1'b1;
    step(s);
    // Request and ack in the same RUN cycle: no stall.
    s = idle(); s.req = 1'b1; s.ack = 1'b1;
    step(s);
    repeat (2) step(idle());

    // Memory timeout, then a reset pulse to recover.
    s = idle(); s.req = 1'b1;
    repeat (TIMEOUT + 5) step(s);
    s.rst = 1'b0;
    repeat (2) step(s);
    repeat (3) step(idle());

    // Halt during MEM_WAIT. The counter must stop.
    s = idle(); s.req = 1'b1;
    repeat (2) step(s);
    s.halt = 1'b1;
    step(s);
    s.halt = 1'b0;
    repeat (5) step(s);
    s = idle(); s.rst = 1'b0;
    step(s);

    // Random traffic on a small register space, so hazards are frequent.
    // The ack rate alternates between phases so that some phases reach the
    // timeout.
    for (int i = 0; i < 4000; i++) begin
      s.rst   = ($urandom_range(99) >= 2);
      s.rs1   = 5'($urandom_range(3));
      s.rs2   = 5'($urandom_range(3));
      s.rd    = 5'($urandom_range(3));
      s.memrd = ($urandom_range(1) == 1);
      s.br    = ($urandom_range(3) == 0);
      s.req   = ($urandom_range(2) == 0);
      s.ack   = ((i % 800) < 400) ? ($urandom_range(1) == 1) : ($urandom_range(19) == 0);
      s.halt  = ($urandom_range(149) == 0);
      step(s);
    end

    // Let the monitor drain the queue. The wait is bounded.
    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
